// File: rtl/led_pwm_driver.sv
// led_pwm_driver: 16-step PWM dimmer for the 24 board LEDs.
// Pattern and config changes are applied only at frame boundaries, so no
// frame is ever glitched. The optional blink feature is compiled in when
// LED_PWM_BLINK_EN is defined. BLINK_FRAMES sets frames per blink half-period.
module led_pwm_driver #(
  parameter int unsigned PRESCALE     = 100,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] led_in,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_data,
  output logic [23:0] led_out,
  output logic        frame_start
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Reject illegal parameter values at elaboration time.
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("led_pwm_driver: PRESCALE must be 1..65535");
  end
  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 1023) begin : g_bad_blink_frames
    $error("led_pwm_driver: BLINK_FRAMES must be 1..1023");
  end

  logic [PRE_W-1:0] pre_cnt;
  logic [3:0]       pwm_cnt;
  logic [23:0]      active_led;
  logic [3:0]       pend_duty;
  logic [3:0]       act_duty;
  logic [3:0]       next_duty;
  logic             tick;
  logic             boundary;
  logic             phase_on;
  logic [23:0]      led_next;

  assign tick      = (pre_cnt == PRE_W'(PRESCALE - 1));
  assign boundary  = tick && (pwm_cnt == 4'hF);
  // A config write landing on the boundary goes live in the frame it opens.
  assign next_duty = cfg_we ? cfg_data[3:0] : pend_duty;

`ifdef LED_PWM_BLINK_EN
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic             pend_blink;
  logic             act_blink;
  logic             next_blink;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_on;
  logic             unused_cfg;

  assign next_blink = cfg_we ? cfg_data[4] : pend_blink;
  assign phase_on   = blink_on;
  assign unused_cfg = ^cfg_data[7:5];

  // Blink state: count frames while blinking stays enabled across a boundary,
  // toggling the phase every BLINK_FRAMES frames; otherwise hold ON and zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_blink <= 1'b0;
      act_blink  <= 1'b0;
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
    end else begin
      if (cfg_we) begin
        pend_blink <= cfg_data[4];
      end
      if (boundary) begin
        act_blink <= next_blink;
        if (next_blink && act_blink) begin
          if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end else begin
          blink_cnt <= '0;
          blink_on  <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_cfg;

  assign phase_on   = 1'b1;
  assign unused_cfg = ^cfg_data[7:4];
`endif

  // Output pattern for the current PWM step, before the output register.
  always_comb begin
    // NOTE: default assignment first so no path leaves led_next unassigned (no latch).
    led_next = '0;
    if (phase_on && ((act_duty == 4'hF) || (pwm_cnt < act_duty))) begin
      led_next = active_led;
    end
  end

  // Prescaler, PWM step counter, frame-boundary loads and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      active_led  <= '0;
      pend_duty   <= 4'hF;
      act_duty    <= 4'hF;
      led_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      if (cfg_we) begin
        pend_duty <= cfg_data[3:0];
      end
      if (boundary) begin
        active_led <= led_in;
        act_duty   <= next_duty;
      end
      frame_start <= boundary;
      led_out     <= led_next;
    end
  end

endmodule
